// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   - stateT      : controller states (IDLE, SHIFT, DONE)
//   - WIDTH_MIN/MAX : legal operand width range
//   - cntWidth()  : width of the bit counter for a given operand width
package serial_adder_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

   // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
   // Floor of 1 keeps the vector legal for degenerate widths.
   function automatic int cntWidth(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Start/done handshake bundle between a requester and serial_adder.
//   master : drives start, a, b, cin; observes busy, done, sum, cout
//   slave  : the adder side (inverse directions)
interface serial_adder_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/serial_adder_fa_bit_cell.sv
// fa_bit_cell
//   Purely combinational one-bit full adder.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_bit_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial, LSB-first adder. One operand bit pair per clock goes through
//   a single fa_bit_cell; the cell's carry-out is registered and fed back as
//   the next carry-in. A result takes WIDTH+1 cycles from accepted start to
//   the done pulse.
//
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout out)
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | one bit per cycle through the cell, busy=1
//   DONE  | done=1 for one cycle; start here chains straight into SHIFT
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int CNT_W = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gBadWidth
      $error("serial_adder: WIDTH out of range");
   end

   stateT            state;
   logic [WIDTH-1:0] shiftA;
   logic [WIDTH-1:0] shiftB;
   logic             carry;
   // Only WIDTH-1 earlier sum bits need holding; the last bit comes
   // straight from the cell on the final edge.
   logic [WIDTH-2:0] partial;
   logic [CNT_W-1:0] bitCount;
   logic             busyReg;
   logic             doneReg;
   logic [WIDTH-1:0] sumReg;
   logic             coutReg;

   logic             cellSum;
   logic             cellCarry;
   logic [WIDTH-1:0] nextResult;

   fa_bit_cell uCell (
      .a  (shiftA[0]),
      .b  (shiftB[0]),
      .ci (carry),
      .s  (cellSum),
      .co (cellCarry)
   );

   assign nextResult = {cellSum, partial};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shiftA   <= '0;
         shiftB   <= '0;
         carry    <= 1'b0;
         partial  <= '0;
         bitCount <= '0;
         busyReg  <= 1'b0;
         doneReg  <= 1'b0;
         sumReg   <= '0;
         coutReg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               doneReg <= 1'b0;
               if (bus.start) begin
                  shiftA   <= bus.a;
                  shiftB   <= bus.b;
                  carry    <= bus.cin;
                  bitCount <= '0;
                  busyReg  <= 1'b1;
                  state    <= SHIFT;
               end
            end

            SHIFT: begin
               carry   <= cellCarry;
               partial <= nextResult[WIDTH-1:1];
               shiftA  <= shiftA >> 1;
               shiftB  <= shiftB >> 1;
               if (bitCount == LAST_BIT) begin
                  // Counter holds here rather than wrapping.
                  sumReg  <= nextResult;
                  coutReg <= cellCarry;
                  busyReg <= 1'b0;
                  doneReg <= 1'b1;
                  state   <= DONE;
               end else begin
                  bitCount <= bitCount + 1'b1;
               end
            end

            DONE: begin
               doneReg <= 1'b0;
               if (bus.start) begin
                  shiftA   <= bus.a;
                  shiftB   <= bus.b;
                  carry    <= bus.cin;
                  bitCount <= '0;
                  busyReg  <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               busyReg <= 1'b0;
               doneReg <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busyReg;
   assign bus.done = doneReg;
   assign bus.sum  = sumReg;
   assign bus.cout = coutReg;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a one-cycle start; returns at the negedge after the accepting edge
   // (first busy cycle).
   task automatic doStart(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ai;
      bus.b     = bi;
      bus.cin   = ci;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Watches negedges starting at the current one (cycle 1) until done or 40
   // cycles. Optionally pulses start with a=pulseA at cycle pulseAt.
   task automatic observe(input int pulseAt, input logic [7:0] pulseA, input logic [7:0] refSum,
                          output int doneCyc, output int nBusy, output bit overlap,
                          output bit changed);
      doneCyc = 0;
      nBusy   = 0;
      overlap = 1'b0;
      changed = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (bus.busy === 1'b1) nBusy++;
         if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
         if (bus.done === 1'b1) begin
            doneCyc = cyc;
            break;
         end
         if (bus.sum !== refSum) changed = 1'b1;
         if (cyc == pulseAt) begin
            bus.start = 1'b1;
            bus.a     = pulseA;
         end else if (cyc == pulseAt + 1) begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_add(input string name, input logic [7:0] ai, input logic [7:0] bi,
                           input logic ci, input logic [7:0] expSum, input logic expCout);
      int dc, nb;
      bit ov, ch;
      logic [7:0] prevSum;
      @(negedge clk);
      prevSum = bus.sum;
      doStart(ai, bi, ci);
      observe(0, 8'h00, prevSum, dc, nb, ov, ch);
      checks++; if (dc !== 9) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 9", name, dc); end
      checks++; if (nb !== 8) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 8", name, nb); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s_busy_done_overlap: got %b expected 0", name, ov); end
      checks++; if (ch !== 1'b0) begin errors++; $display("FAIL %s_partial_visible: got %b expected 0", name, ch); end
      checks++; if (bus.sum !== expSum) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, bus.sum, expSum); end
      checks++; if (bus.cout !== expCout) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, bus.cout, expCout); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, bus.done); end
      checks++; if (bus.sum !== expSum) begin errors++; $display("FAIL %s_sum_held: got %h expected %h", name, bus.sum, expSum); end
   endtask

   task automatic test_ignore_start;
      int dc, nb;
      bit ov, ch;
      logic [7:0] prevSum;
      @(negedge clk);
      prevSum = bus.sum;
      doStart(8'h10, 8'h20, 1'b0);
      observe(4, 8'h77, prevSum, dc, nb, ov, ch);
      checks++; if (dc !== 9) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 9", dc); end
      checks++; if (nb !== 8) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 8", nb); end
      checks++; if (bus.sum !== 8'h30) begin errors++; $display("FAIL ignore_sum: got %h expected 30", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b expected 0", bus.cout); end
   endtask

   task automatic test_back_to_back;
      int dc, nb;
      bit ov, ch;
      // Still in the DONE cycle left by the previous test.
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_in_done: got %b expected 1", bus.done); end
      bus.start = 1'b1;
      bus.a     = 8'h01;
      bus.b     = 8'h02;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_next: got %b expected 1", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_next: got %b expected 0", bus.done); end
      observe(0, 8'h00, 8'h30, dc, nb, ov, ch);
      checks++; if (dc !== 9) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 9", dc); end
      checks++; if (ch !== 1'b0) begin errors++; $display("FAIL b2b_partial_visible: got %b expected 0", ch); end
      checks++; if (bus.sum !== 8'h03) begin errors++; $display("FAIL b2b_sum: got %h expected 03", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL b2b_cout: got %b expected 0", bus.cout); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int dc, nb;
      bit ov, ch;
      bit sawDone;
      doStart(8'hAA, 8'h55, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b expected 0", bus.busy); end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL mid_sum_async: got %h expected 00", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL mid_cout_async: got %b expected 0", bus.cout); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
      end
      checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL mid_no_activity: got %b expected 0", sawDone); end
      checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL mid_sum_after: got %h expected 00", bus.sum); end
      doStart(8'h0F, 8'h01, 1'b0);
      observe(0, 8'h00, 8'h00, dc, nb, ov, ch);
      checks++; if (dc !== 9) begin errors++; $display("FAIL fresh_done_cycle: got %0d expected 9", dc); end
      checks++; if (bus.sum !== 8'h10) begin errors++; $display("FAIL fresh_sum: got %h expected 10", bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL fresh_cout: got %b expected 0", bus.cout); end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b1;
      bus.start = 1'b0;
      bus.a     = 8'h00;
      bus.b     = 8'h00;
      bus.cin   = 1'b0;
      test_reset();
      test_add("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      test_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      test_add("max", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      test_add("cin", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first adder that sits directly upstream of the one-bit full-adder cell and drives it one operand bit pair per clock. It feeds the cell's carry-out back into its carry-in through a register. It also collects the sum bits into a WIDTH-bit result. It trades the area of a ripple-carry chain for WIDTH+1 cycles of latency behind a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2–32
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; all state cleared immediately on assertion, released synchronously to clk
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  augend; captured on accepted start
- b  input  WIDTH  addend; captured on accepted start
- cin  input  1  initial carry; captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; sum and cout valid from this cycle
- sum  output  WIDTH  registered result; held stable until the next DONE
- cout  output  1  registered final carry; held like sum

## Operation
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; internal shift registers, carry register and bit counter all cleared.
- States: IDLE, SHIFT, DONE.
  - IDLE: if start=1, load a→ra, b→rb, cin→carry, counter=0, go to SHIFT; otherwise stay.
  - SHIFT, one bit per cycle:
    - the full-adder cell receives ra[0], rb[0] and carry;
    - carry←cell carry-out;
    - result shift register shifts right with the cell sum entering at bit WIDTH-1;
    - ra and rb shift right;
    - counter increments.
    - When counter==WIDTH-1 at the edge, go to DONE. On that edge, sum←completed result and cout←cell carry-out.
  - DONE: done=1 for exactly this cycle.
    - If start=1, load new operands and go to SHIFT; this gives back-to-back operation with no IDLE gap.
    - Otherwise go to IDLE.
- start is ignored while in SHIFT: operands are not re-captured and the count does not restart.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); exact for all inputs.
- sum/cout never change except on the SHIFT→DONE edge or on reset. No partial results are ever visible.
- Counter width is clog2(WIDTH). It never wraps past WIDTH-1.
- Reset mid-operation: the operation is abandoned. Outputs return to reset values, done is not pulsed, and the next start is a fresh operation.

## Timing
- Start sampled high at edge k (state IDLE or DONE) → busy high from k through k+WIDTH.
- DONE is entered at edge k+WIDTH; done=1 and sum/cout valid in the cycle after edge k+WIDTH.
- Latency start→done: WIDTH+1 cycles.
- Maximum throughput: one addition per WIDTH+1 cycles.
- busy and done are never high together.
- done is registered (state-decoded, no combinational path from inputs).
- The full-adder path is combinational between the ra/rb/carry registers and the carry/result registers: one cell delay per cycle.

## Structure
- Shared package `serial_adder_pkg`:
  - state enum (IDLE, SHIFT, DONE);
  - WIDTH limits;
  - counter-width function.
- Sub-module `fa_bit_cell`: a purely combinational one-bit full adder, instantiated once. Ports: a, b, ci, s, co.
- Top-level block: FSM, counter, shift registers, carry register and output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst_n=0 mid-cycle → outputs 0 immediately, without waiting for an edge.
- Basic add: a=0x5A, b=0x3C, cin=0, start for one cycle → busy for 8 cycles, done pulse on the 9th; sum=0x96, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
- Maximum inputs: a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start ignored while busy:
  - start 0x10+0x20, then pulse start with a=0x77 at the 4th busy cycle → result 0x30, cout=0, done after 9 cycles total.
  - Back-to-back: start held during DONE with a=0x01, b=0x02 → busy next cycle, second result 0x03.
- Reset mid-operation: rst_n=0 at the 5th SHIFT cycle of 0xAA+0x55 → no done pulse, sum stays 0x00. A following start of 0x0F+0x01 → 0x10, cout=0.
